// File: rtl/daq_usb_stream_buffer_pkg.sv
// rtl/daq_usb_stream_buffer_pkg.sv - shared state encoding and constants for the DAQ-to-USB stream buffer
package daq_usb_stream_buffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_CHECKSUM = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [15:0] WORD_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/daq_sync_fifo.sv
// rtl/daq_sync_fifo.sv - single-clock 16-bit FIFO with full/empty flags and occupancy
//
// Ports:
//   i_clk, i_rst_n         clock, synchronous active-low reset (pointers/occupancy only)
//   i_wr_en, i_wr_data     write strobe and word; the caller only writes when full if it also reads
//   i_rd_en, o_rd_data     read strobe; o_rd_data shows the head word combinationally
//   o_full, o_empty        occupancy flags
//   o_level                occupancy, ADDR_W+1 bits so that a full FIFO is representable
module daq_sync_fifo #(
    parameter int FIFO_DEPTH = 512,
    parameter int ADDR_W     = 9
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [15:0]       i_wr_data,
    input  logic              i_rd_en,
    output logic [15:0]       o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(FIFO_DEPTH);

    logic [15:0]       r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({i_wr_en, i_rd_en})
                2'b10:   r_level <= r_level + (ADDR_W + 1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = (r_level == LP_DEPTH);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;

endmodule

// File: rtl/daq_usb_stream_buffer.sv
// rtl/daq_usb_stream_buffer.sv - buffers the DAQ word stream and drains it to the USB FIFO with end-of-run handshake
//
// Optional feature macro: DAQ_STREAM_CHECKSUM_EN (appends an XOR checksum word after the run drain).
//
// Ports:
//   Clk, reset_n                      clock, synchronous active-low reset
//   SlaveDaqData, SlaveDaqData_en     incoming DAQ words, one per strobe cycle
//   AllDone                           run finished upstream; starts the flush
//   UsbFifoFull                       USB back-pressure, blocks reads
//   UsbData, UsbData_en               registered output word and write strobe
//   DataTransmitDone                  high while in DONE
//   Overflow                          sticky dropped-word flag
//   WordCount                         saturating count of data words sent this run
module daq_usb_stream_buffer
    import daq_usb_stream_buffer_pkg::*;
#(
    parameter int FIFO_DEPTH = 512,
    parameter int ADDR_W     = 9
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic [15:0] SlaveDaqData,
    input  logic        SlaveDaqData_en,
    input  logic        AllDone,
    input  logic        UsbFifoFull,
    output logic [15:0] UsbData,
    output logic        UsbData_en,
    output logic        DataTransmitDone,
    output logic        Overflow,
    output logic [15:0] WordCount
);

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_usb_data;
    logic              r_usb_en;
    logic              r_overflow;
    logic [15:0]       r_word_count;

    logic [15:0]       w_rd_data;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W:0]   w_level;
    logic              w_active;
    logic              w_rd;
    logic              w_wr;
    logic              w_drop;
    logic              w_flush_done;
    logic              w_run_clear;

`ifdef DAQ_STREAM_CHECKSUM_EN
    logic [15:0]       r_csum;
    logic              w_csum_emit;
    assign w_csum_emit = (r_state == ST_CHECKSUM) && !UsbFifoFull;
`endif

    assign w_active = (r_state == ST_IDLE) || (r_state == ST_DRAIN) || (r_state == ST_FLUSH);
    assign w_rd     = w_active && !w_empty && !UsbFifoFull;
    // A full FIFO still accepts a word when the same cycle frees a slot.
    assign w_wr     = w_active && SlaveDaqData_en && (!w_full || w_rd);
    assign w_drop   = w_active && SlaveDaqData_en && w_full && !w_rd;
    // Drain is complete only once the last word has left the output register.
    assign w_flush_done = (w_level == '0) && !SlaveDaqData_en && !r_usb_en;
    assign w_run_clear  = (r_state == ST_DONE) && !AllDone;

    daq_sync_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_fifo (
        .i_clk     (Clk),
        .i_rst_n   (reset_n),
        .i_wr_en   (w_wr),
        .i_wr_data (SlaveDaqData),
        .i_rd_en   (w_rd),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (AllDone) begin
                    w_next = ST_FLUSH;
                end else if (SlaveDaqData_en) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (AllDone) begin
                    w_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_flush_done) begin
`ifdef DAQ_STREAM_CHECKSUM_EN
                    w_next = ST_CHECKSUM;
`else
                    w_next = ST_DONE;
`endif
                end
            end
`ifdef DAQ_STREAM_CHECKSUM_EN
            ST_CHECKSUM: begin
                if (!UsbFifoFull) begin
                    w_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (!AllDone) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            r_usb_data   <= '0;
            r_usb_en     <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_usb_en <= 1'b0;
            if (w_rd) begin
                r_usb_data <= w_rd_data;
                r_usb_en   <= 1'b1;
            end
`ifdef DAQ_STREAM_CHECKSUM_EN
            else if (w_csum_emit) begin
                r_usb_data <= r_csum;
                r_usb_en   <= 1'b1;
            end
`endif

            if (w_run_clear) begin
                r_word_count <= '0;
            end else if (w_rd && (r_word_count != WORD_COUNT_MAX)) begin
                r_word_count <= r_word_count + 16'd1;
            end

            if (w_run_clear) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef DAQ_STREAM_CHECKSUM_EN
    always_ff @(posedge Clk) begin
        if (!reset_n || w_run_clear) begin
            r_csum <= '0;
        end else if (w_rd) begin
            r_csum <= r_csum ^ w_rd_data;
        end
    end
`endif

    assign UsbData          = r_usb_data;
    assign UsbData_en       = r_usb_en;
    assign DataTransmitDone = (r_state == ST_DONE);
    assign Overflow         = r_overflow;
    assign WordCount        = r_word_count;

endmodule

// File: tb/tb_daq_usb_stream_buffer.sv
// tb/tb_daq_usb_stream_buffer.sv - directed self-checking bench for daq_usb_stream_buffer
module tb_daq_usb_stream_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef DAQ_STREAM_CHECKSUM_EN
    localparam int CSUM_WORDS = 1;
`else
    localparam int CSUM_WORDS = 0;
`endif

    logic        Clk = 1'b0;
    logic        reset_n;
    logic [15:0] SlaveDaqData;
    logic        SlaveDaqData_en;
    logic        AllDone;
    logic        UsbFifoFull;
    logic [15:0] UsbData;
    logic        UsbData_en;
    logic        DataTransmitDone;
    logic        Overflow;
    logic [15:0] WordCount;

    int n_checks = 0;
    int n_fail   = 0;
    int n_tot    = 0;
    logic [15:0] log_mem [0:4095];

    always #5 Clk = ~Clk;

    daq_usb_stream_buffer #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .Clk              (Clk),
        .reset_n          (reset_n),
        .SlaveDaqData     (SlaveDaqData),
        .SlaveDaqData_en  (SlaveDaqData_en),
        .AllDone          (AllDone),
        .UsbFifoFull      (UsbFifoFull),
        .UsbData          (UsbData),
        .UsbData_en       (UsbData_en),
        .DataTransmitDone (DataTransmitDone),
        .Overflow         (Overflow),
        .WordCount        (WordCount)
    );

    always @(negedge Clk) begin
        if (UsbData_en === 1'b1) begin
            log_mem[n_tot % 4096] = UsbData;
            n_tot = n_tot + 1;
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; SlaveDaqData = '0; SlaveDaqData_en = 1'b0;
        AllDone = 1'b0; UsbFifoFull = 1'b0;
        tick; tick;
        n_checks++; if (UsbData !== 16'h0) begin n_fail++; $display("FAIL reset_usbdata got %h want 0000", UsbData); end
        n_checks++; if (UsbData_en !== 1'b0) begin n_fail++; $display("FAIL reset_usben got %b want 0", UsbData_en); end
        n_checks++; if (DataTransmitDone !== 1'b0) begin n_fail++; $display("FAIL reset_dtd got %b want 0", DataTransmitDone); end
        n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", Overflow); end
        n_checks++; if (WordCount !== 16'h0) begin n_fail++; $display("FAIL reset_wc got %0d want 0", WordCount); end
        n_checks++; if (dut.r_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", dut.r_state); end
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        int base;
        base = n_tot;
        SlaveDaqData = 16'h1111; SlaveDaqData_en = 1'b1;
        tick;
        n_checks++; if (UsbData_en !== 1'b0) begin n_fail++; $display("FAIL basic_latency_n1 got en=%b want 0", UsbData_en); end
        SlaveDaqData = 16'h2222;
        tick;
        n_checks++; if (UsbData_en !== 1'b1 || UsbData !== 16'h1111) begin n_fail++; $display("FAIL basic_word0 got en=%b data=%h want 1 1111", UsbData_en, UsbData); end
        SlaveDaqData = 16'hFF45;
        tick;
        SlaveDaqData_en = 1'b0;
        n_checks++; if (UsbData_en !== 1'b1 || UsbData !== 16'h2222) begin n_fail++; $display("FAIL basic_word1 got en=%b data=%h want 1 2222", UsbData_en, UsbData); end
        tick;
        n_checks++; if (UsbData_en !== 1'b1 || UsbData !== 16'hFF45) begin n_fail++; $display("FAIL basic_word2 got en=%b data=%h want 1 ff45", UsbData_en, UsbData); end
        tick;
        n_checks++; if (UsbData_en !== 1'b0 || UsbData !== 16'hFF45) begin n_fail++; $display("FAIL basic_hold got en=%b data=%h want 0 ff45", UsbData_en, UsbData); end
        n_checks++; if (WordCount !== 16'd3) begin n_fail++; $display("FAIL basic_wordcount got %0d want 3", WordCount); end
        n_checks++; if (n_tot - base !== 3) begin n_fail++; $display("FAIL basic_emitted got %0d want 3", n_tot - base); end
    endtask

    task automatic test_overflow;
        int base;
        int errs;
        int waited;
        UsbFifoFull = 1'b1;
        base = n_tot;
        for (int i = 0; i < DEPTH + 2; i++) begin
            SlaveDaqData = 16'h0100 + 16'(i); SlaveDaqData_en = 1'b1;
            tick;
        end
        SlaveDaqData_en = 1'b0;
        tick;
        n_checks++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", Overflow); end
        n_checks++; if (n_tot - base !== 0) begin n_fail++; $display("FAIL ovf_blocked got %0d words want 0", n_tot - base); end
        UsbFifoFull = 1'b0;
        base = n_tot;
        repeat (DEPTH + 6) tick;
        n_checks++; if (n_tot - base !== DEPTH) begin n_fail++; $display("FAIL ovf_count got %0d want %0d", n_tot - base, DEPTH); end
        errs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (log_mem[(base + i) % 4096] !== 16'h0100 + 16'(i)) errs++;
        end
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL ovf_order got %0d bad words want 0", errs); end
        n_checks++; if (WordCount !== 16'(3 + DEPTH)) begin n_fail++; $display("FAIL ovf_wordcount got %0d want %0d", WordCount, 3 + DEPTH); end
        AllDone = 1'b1;
        waited = 0;
        while (DataTransmitDone !== 1'b1 && waited < 40) begin tick; waited++; end
        n_checks++; if (DataTransmitDone !== 1'b1) begin n_fail++; $display("FAIL ovf_end_dtd got %b want 1 (timeout)", DataTransmitDone); end
        AllDone = 1'b0;
        tick;
        n_checks++; if (DataTransmitDone !== 1'b0 || WordCount !== 16'h0 || Overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear got dtd=%b wc=%0d ovf=%b want 0 0 0", DataTransmitDone, WordCount, Overflow);
        end
    endtask

    task automatic test_alldone_stream;
        int base;
        int early;
        int waited;
        int at_rise;
        base = n_tot;
        early = 0;
        for (int i = 0; i < 10; i++) begin
            SlaveDaqData = 16'h0A00 + 16'(i); SlaveDaqData_en = 1'b1;
            if (i == 3) AllDone = 1'b1;
            tick;
            if (DataTransmitDone !== 1'b0) early++;
        end
        SlaveDaqData_en = 1'b0;
        waited = 0;
        while (DataTransmitDone !== 1'b1 && waited < 40) begin
            tick; waited++;
            if (DataTransmitDone === 1'b1 && (n_tot - base) < 10) early++;
        end
        at_rise = n_tot - base;
        n_checks++; if (DataTransmitDone !== 1'b1) begin n_fail++; $display("FAIL ad_dtd_rise got %b want 1 (timeout)", DataTransmitDone); end
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL ad_early_dtd got %0d early cycles want 0", early); end
        n_checks++; if (at_rise !== 10 + CSUM_WORDS) begin n_fail++; $display("FAIL ad_words_at_rise got %0d want %0d", at_rise, 10 + CSUM_WORDS); end
        n_checks++; if (log_mem[(base + 9) % 4096] !== 16'h0A09) begin n_fail++; $display("FAIL ad_last_word got %h want 0a09", log_mem[(base + 9) % 4096]); end
        n_checks++; if (WordCount !== 16'd10) begin n_fail++; $display("FAIL ad_wordcount got %0d want 10", WordCount); end
        AllDone = 1'b0;
        tick;
        n_checks++; if (DataTransmitDone !== 1'b0 || WordCount !== 16'h0 || Overflow !== 1'b0) begin
            n_fail++; $display("FAIL ad_clear got dtd=%b wc=%0d ovf=%b want 0 0 0", DataTransmitDone, WordCount, Overflow);
        end
    endtask

    task automatic test_full_rw;
        int base;
        int waited;
        UsbFifoFull = 1'b1;
        base = n_tot;
        for (int i = 0; i < DEPTH; i++) begin
            SlaveDaqData = 16'h0C00 + 16'(i); SlaveDaqData_en = 1'b1;
            tick;
        end
        SlaveDaqData = 16'hBEEF; UsbFifoFull = 1'b0;
        tick;
        SlaveDaqData_en = 1'b0;
        n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL frw_ovf got %b want 0", Overflow); end
        repeat (DEPTH + 6) tick;
        n_checks++; if (n_tot - base !== DEPTH + 1) begin n_fail++; $display("FAIL frw_count got %0d want %0d", n_tot - base, DEPTH + 1); end
        n_checks++; if (log_mem[base % 4096] !== 16'h0C00) begin n_fail++; $display("FAIL frw_first got %h want 0c00", log_mem[base % 4096]); end
        n_checks++; if (log_mem[(base + DEPTH) % 4096] !== 16'hBEEF) begin n_fail++; $display("FAIL frw_last got %h want beef", log_mem[(base + DEPTH) % 4096]); end
        n_checks++; if (WordCount !== 16'(DEPTH + 1)) begin n_fail++; $display("FAIL frw_wordcount got %0d want %0d", WordCount, DEPTH + 1); end
        AllDone = 1'b1;
        waited = 0;
        while (DataTransmitDone !== 1'b1 && waited < 40) begin tick; waited++; end
        n_checks++; if (DataTransmitDone !== 1'b1) begin n_fail++; $display("FAIL frw_end_dtd got %b want 1 (timeout)", DataTransmitDone); end
        AllDone = 1'b0;
        tick;
    endtask

`ifdef DAQ_STREAM_CHECKSUM_EN
    task automatic test_checksum;
        int base;
        int waited;
        base = n_tot;
        SlaveDaqData = 16'hA5A5; SlaveDaqData_en = 1'b1;
        tick;
        SlaveDaqData = 16'h0F0F;
        tick;
        SlaveDaqData_en = 1'b0;
        AllDone = 1'b1;
        waited = 0;
        while (DataTransmitDone !== 1'b1 && waited < 40) begin tick; waited++; end
        n_checks++; if (DataTransmitDone !== 1'b1) begin n_fail++; $display("FAIL cs_dtd got %b want 1 (timeout)", DataTransmitDone); end
        n_checks++; if (n_tot - base !== 3) begin n_fail++; $display("FAIL cs_words got %0d want 3", n_tot - base); end
        n_checks++; if (log_mem[(base + 2) % 4096] !== 16'hAAAA) begin n_fail++; $display("FAIL cs_value got %h want aaaa", log_mem[(base + 2) % 4096]); end
        n_checks++; if (WordCount !== 16'd2) begin n_fail++; $display("FAIL cs_wordcount got %0d want 2", WordCount); end
        AllDone = 1'b0;
        tick;
    endtask
`endif

    task automatic test_reset_flush;
        int base;
        UsbFifoFull = 1'b1;
        base = n_tot;
        for (int i = 0; i < 5; i++) begin
            SlaveDaqData = 16'h0E00 + 16'(i); SlaveDaqData_en = 1'b1;
            tick;
        end
        SlaveDaqData_en = 1'b0;
        AllDone = 1'b1;
        repeat (8) tick;
        n_checks++; if (DataTransmitDone !== 1'b0) begin n_fail++; $display("FAIL rf_stuck_dtd got %b want 0", DataTransmitDone); end
        n_checks++; if (dut.r_state !== 3'd2) begin n_fail++; $display("FAIL rf_in_flush got %0d want 2", dut.r_state); end
        reset_n = 1'b0; UsbFifoFull = 1'b0; AllDone = 1'b0;
        tick;
        n_checks++; if (UsbData !== 16'h0 || UsbData_en !== 1'b0 || DataTransmitDone !== 1'b0 || Overflow !== 1'b0 || WordCount !== 16'h0) begin
            n_fail++; $display("FAIL rf_outputs got data=%h en=%b dtd=%b ovf=%b wc=%0d want all 0", UsbData, UsbData_en, DataTransmitDone, Overflow, WordCount);
        end
        n_checks++; if (dut.r_state !== 3'd0) begin n_fail++; $display("FAIL rf_state got %0d want 0", dut.r_state); end
        reset_n = 1'b1;
        repeat (10) tick;
        n_checks++; if (n_tot - base !== 0) begin n_fail++; $display("FAIL rf_discard got %0d words want 0", n_tot - base); end
        SlaveDaqData = 16'h7777; SlaveDaqData_en = 1'b1;
        tick;
        SlaveDaqData_en = 1'b0;
        tick;
        n_checks++; if (UsbData_en !== 1'b1 || UsbData !== 16'h7777) begin n_fail++; $display("FAIL rf_after got en=%b data=%h want 1 7777", UsbData_en, UsbData); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overflow;
        test_alldone_stream;
        test_full_rw;
`ifdef DAQ_STREAM_CHECKSUM_EN
        test_checksum;
`endif
        test_reset_flush;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
